// File: rtl/conbus_rr_arb.sv
// Round-robin arbiter for the conbus shared-bus interconnect: registered one-hot grant,
// hold-while-cyc ownership, parked when idle. Optional ack watchdog under CONBUS_ARB_WDT_EN.
module conbus_rr_arb #(
    parameter int N_MASTERS  = 7,
    parameter int WDT_CYCLES = 256
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [N_MASTERS-1:0] req,
    input  logic [N_MASTERS-1:0] req_mask,
    input  logic                 ack_i,
    output logic [N_MASTERS-1:0] gnt,
    output logic [2:0]           gnt_id,
    output logic                 busy
`ifdef CONBUS_ARB_WDT_EN
    ,
    output logic                 wdt_err
`endif
);

    // Requests widened to 8 bits so a 3-bit index is always a legal select.
    logic [7:0] req8;
    logic [7:0] elig8;
    logic [2:0] nxt_id;
    logic       rotate;

    function automatic logic [N_MASTERS-1:0] onehot(input logic [2:0] id);
        onehot = {{(N_MASTERS-1){1'b0}}, 1'b1} << id;
    endfunction

    assign req8   = 8'(req);
    assign elig8  = 8'(req & ~req_mask);
    assign busy   = req8[gnt_id];
    assign rotate = !busy && (elig8 != 8'd0);

    // Scan starts just after the owner and visits the owner last.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        nxt_id = gnt_id;
        found  = 1'b0;
        idx    = 3'd0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = 3'((int'(gnt_id) + k) % N_MASTERS);
            if (!found && elig8[idx]) begin
                nxt_id = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gnt_id <= 3'd0;
            gnt    <= onehot(3'd0);
        end else if (rotate) begin
            gnt_id <= nxt_id;
            gnt    <= onehot(nxt_id);
        end
    end

`ifdef CONBUS_ARB_WDT_EN
    localparam logic [15:0] WDT_MAX = 16'(WDT_CYCLES);

    logic [15:0] wcnt;
    logic        wdt_clr;

    // A grant change always follows an idle owner, so !busy also covers it.
    assign wdt_clr = ack_i || !busy || rotate;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wcnt    <= 16'd0;
            wdt_err <= 1'b0;
        end else if (wdt_clr) begin
            wcnt    <= 16'd0;
            wdt_err <= 1'b0;
        end else begin
            wdt_err <= (wcnt == WDT_MAX - 16'd1);
            if (wcnt != WDT_MAX)
                wcnt <= wcnt + 16'd1;
        end
    end
`else
    logic unused_ack;
    assign unused_ack = ack_i;
`endif

endmodule

// File: tb/tb_conbus_rr_arb.sv
// Scoreboard bench for conbus_rr_arb; watchdog checks compile in when CONBUS_ARB_WDT_EN is defined.
module tb_conbus_rr_arb;
    localparam int N = 7;
    localparam int W = 8;

    logic         sys_clk  = 1'b0;
    logic         sys_rst  = 1'b0;
    logic [N-1:0] req      = '0;
    logic [N-1:0] req_mask = '0;
    logic         ack_i    = 1'b0;
    logic [N-1:0] gnt;
    logic [2:0]   gnt_id;
    logic         busy;
`ifdef CONBUS_ARB_WDT_EN
    logic         wdt_err;
`endif

    conbus_rr_arb #(.N_MASTERS(N), .WDT_CYCLES(W)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req      (req),
        .req_mask (req_mask),
        .ack_i    (ack_i),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .busy     (busy)
`ifdef CONBUS_ARB_WDT_EN
        ,
        .wdt_err  (wdt_err)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]   id;
        logic [N-1:0] g;
        logic         e;
    } exp_t;

    exp_t sbq[$];
    int   m_id  = 0;
    int   m_cnt = 0;
    logic m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_id  = 0;
        m_cnt = 0;
        m_err = 1'b0;
        sbq.delete();
    endtask

    // One clock: predict from current inputs, push, wait the edge, pop and compare.
    task automatic step();
        exp_t         e;
        exp_t         o;
        logic [N-1:0] el;
        logic         own_req;
        int           nid;
        el      = req & ~req_mask;
        own_req = req[3'(m_id)];
        nid     = m_id;
        if (!own_req && el != '0)
            for (int k = N; k >= 1; k--)
                if (el[3'((m_id + k) % N)]) nid = (m_id + k) % N;
        if (ack_i || !own_req) begin
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            m_err = (m_cnt == W - 1);
            if (m_cnt < W) m_cnt++;
        end
        m_id = nid;
        e.id = 3'(m_id);
        e.g  = '0;
        e.g[3'(m_id)] = 1'b1;
        e.e  = m_err;
        sbq.push_back(e);
        @(posedge sys_clk);
        #1;
        o = sbq.pop_front();
        chk("gnt_id", 32'(gnt_id), 32'(o.id));
        chk("gnt", 32'(gnt), 32'(o.g));
`ifdef CONBUS_ARB_WDT_EN
        chk("wdt_err", 32'(wdt_err), 32'(o.e));
`endif
        chk("busy", 32'(busy), 32'(req[3'(m_id)]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int           order[8] = '{1, 2, 3, 4, 5, 6, 0, 1};
        logic [N-1:0] tmp;
        int           pulses;
        int           first_pulse;

        // Reset / park
        #1 sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h1);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        sys_rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) step();
        chk("park_gnt", 32'(gnt), 32'h1);

        // Round-robin fairness: each owner drops for one cycle after 3 cycles of tenure
        req = '1;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 3; i++) step();
            tmp = '1;
            tmp[3'(m_id)] = 1'b0;
            req = tmp;
            step();
            chk("rr_order", 32'(gnt_id), 32'(order[t]));
            req = '1;
        end

        // Hold and masking
        req = 7'b0001000;
        step();
        chk("own3", 32'(gnt_id), 32'd3);
        req_mask = 7'b0001000;
        req      = 7'b0101000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_masked", 32'(gnt_id), 32'd3);
        end
        req = 7'b0100000;
        step();
        chk("to5", 32'(gnt_id), 32'd5);
        req = 7'b0101000;
        step();
        step();
        req = 7'b0001000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_regrant", 32'(gnt_id), 32'd5);
        end

        // Wrap and single requester
        req_mask = '0;
        req      = 7'b1000000;
        step();
        chk("own6", 32'(gnt_id), 32'd6);
        req = 7'b1000100;
        step();
        step();
        req = 7'b0000100;
        step();
        chk("wrap", 32'(gnt_id), 32'd2);
        req = 7'b0000000;
        step();
        chk("single_lo", 32'(gnt_id), 32'd2);
        req = 7'b0000100;
        step();
        chk("single_hi", 32'(gnt_id), 32'd2);

`ifdef CONBUS_ARB_WDT_EN
        // Watchdog: stall without ack, then the same with an ack on the expiring cycle
        req = 7'b0100000;
        step();
        pulses      = 0;
        first_pulse = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (wdt_err === 1'b1) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
        end
        chk("wdt_pulses", 32'(pulses), 32'd1);
        chk("wdt_edge", 32'(first_pulse), 32'd8);
        req = '0;
        step();
        req = 7'b0000010;
        step();
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            ack_i = (i == 8);
            step();
            if (wdt_err === 1'b1) pulses++;
        end
        ack_i = 1'b0;
        chk("wdt_ack_none", 32'(pulses), 32'd0);
        req = '0;
        step();
`endif

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            ack_i = ($urandom_range(0, 15) == 0);
            if (i % 40 == 0) req_mask = N'($urandom_range(0, (1 << N) - 1));
            step();
        end
        req_mask = '0;
        ack_i    = 1'b0;

        // Asynchronous reset during tenure
        req = 7'b0010000;
        step();
        step();
        chk("own4", 32'(gnt_id), 32'd4);
        #2 sys_rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h1);
        chk("arst_gnt_id", 32'(gnt_id), 32'h0);
        model_reset();
        @(posedge sys_clk);
        #1;
        chk("arst_hold", 32'(gnt_id), 32'h0);
        sys_rst = 1'b0;
        step();
        chk("post_rst", 32'(gnt_id), 32'd4);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
